mul_share_arbiter: RTL and testbench

Round-robin arbiter that time-shares one `bmul` fixed-point multiplier (Q8.8 × Q8.8 → Q16.16) among `NREQ` requesters. Typical requesters are matrix-multiply sequencers or other datapath clients. The block sequences the multiplier's reset / `in_rdy` / `res_rdy` protocol, so requesters never drive `bmul` directly. It sits between the requester blocks and a single `bmul` instance, and removes the need for one multiplier per client.

---
 rtl/mul_share_arbiter.sv | 113 +++++++++++
 tb/tb_mul_share_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin arbiter time-sharing one bmul Q8.8 multiplier
// Sequences the bmul reset / in_rdy / res_rdy handshake on behalf of NREQ requesters.
module mul_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*16-1:0] a_in,
  input  logic [NREQ*16-1:0] b_in,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic [NREQ-1:0]    err,
  output logic [31:0]        res,
  output logic               busy,
  output logic               m_rst,
  output logic [15:0]        m_a,
  output logic [15:0]        m_b,
  output logic               m_in_rdy,
  input  logic               m_res_rdy,
  input  logic [31:0]        m_res
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, GRANT, CLR, ISSUE, DONE, ABORT} state_t;

  state_t          state, next;
  logic [IW-1:0]   ptr, cur, win, cand, cur_inc;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] cur_oh;
  logic            timed_out;
  int              j;

  // Scan downward from the farthest candidate so the nearest one at/after ptr wins.
  always_comb begin
    win  = ptr;
    cand = ptr;
    j    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      cand = IW'(j);
      if (req[cand]) win = cand;
    end
  end

  assign cur_inc   = (cur == IW'(NREQ - 1)) ? '0 : cur + 1'b1;
  assign timed_out = (cnt == CW'(TIMEOUT - 1));
  assign cur_oh    = NREQ'(1) << cur;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next;
  end

  // Completion is tested before the watchdog so a late result still wins.
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (|req) next = GRANT;
      GRANT:   next = CLR;
      CLR:     next = ISSUE;
      ISSUE: begin
        if (m_res_rdy)      next = DONE;
        else if (timed_out) next = ABORT;
      end
      DONE:    next = IDLE;
      ABORT:   next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr   <= '0;
      cur   <= '0;
      m_a   <= '0;
      m_b   <= '0;
      res   <= '0;
      cnt   <= '0;
      m_rst <= 1'b1;
    end else begin
      m_rst <= (next == GRANT) || (next == ABORT);
      case (state)
        IDLE: begin
          if (|req) begin
            cur <= win;
            m_a <= a_in[{win, 4'b0000} +: 16];
            m_b <= b_in[{win, 4'b0000} +: 16];
          end
        end
        CLR:   cnt <= '0;
        ISSUE: begin
          cnt <= cnt + 1'b1;
          if (m_res_rdy) res <= m_res;
        end
        DONE:  ptr <= cur_inc;
        ABORT: ptr <= cur_inc;
        default: ;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign m_in_rdy = (state == ISSUE);
  assign gnt      = (state == GRANT) ? cur_oh : '0;
  assign done     = (state == DONE)  ? cur_oh : '0;
  assign err      = (state == ABORT) ? cur_oh : '0;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - self-checking bench for mul_share_arbiter
// Drives requesters and a latency-programmable multiplier model, compares against a transaction-level model.
module tb_mul_share_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*16-1:0] a_in, b_in;
  logic [NREQ-1:0]    gnt, done, err;
  logic [31:0]        res;
  logic               busy, m_rst;
  logic [15:0]        m_a, m_b;
  logic               m_in_rdy, m_res_rdy;
  logic [31:0]        m_res;

  int              checks = 0;
  int              errors = 0;
  int              lat    = 0;
  bit              never  = 1'b0;
  int              iss_k  = 0;
  int              ptr_m  = 0;
  logic [31:0]     res_m  = '0;
  logic [NREQ-1:0] gnt_seen;
  logic [31:0]     res_seen;

  mul_share_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .done(done), .err(err), .res(res), .busy(busy),
    .m_rst(m_rst), .m_a(m_a), .m_b(m_b), .m_in_rdy(m_in_rdy),
    .m_res_rdy(m_res_rdy), .m_res(m_res)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, then let the multiplier model react to in_rdy.
  task automatic tick();
    @(posedge clk);
    #1;
    if (m_in_rdy === 1'b1) begin
      m_res_rdy = !never && (iss_k == lat);
      m_res     = m_res_rdy ? ({16'h0, m_a} * {16'h0, m_b}) : $urandom();
      iss_k++;
    end else begin
      m_res_rdy = 1'($urandom_range(0, 1));
      m_res     = $urandom();
      iss_k     = 0;
    end
  endtask

  // Winner is the requester with the smallest circular distance from the pointer.
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    int best = -1;
    int bd   = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (r[i] && ((i - p + NREQ) % NREQ) < bd) begin
        bd   = (i - p + NREQ) % NREQ;
        best = i;
      end
    end
    return best;
  endfunction

  task automatic scramble();
    req  = NREQ'($urandom());
    a_in = {$urandom(), $urandom()};
    b_in = {$urandom(), $urandom()};
  endtask

  task automatic run_txn(input logic [NREQ-1:0] rq, input int l, input bit nv);
    int w, cyc, ecyc;
    logic [15:0] ea, eb;
    logic [31:0] prod;
    chk("idle_busy", busy, 0);
    lat   = l;
    never = nv;
    req   = rq;
    if (rq == '0) begin
      tick();
      chk("noreq_busy", busy, 0);
      chk("noreq_gnt", gnt, 0);
      return;
    end
    w    = pick(rq, ptr_m);
    ea   = a_in[w*16 +: 16];
    eb   = b_in[w*16 +: 16];
    prod = {16'h0, ea} * {16'h0, eb};
    tick();
    gnt_seen = gnt;
    chk("gnt", gnt, 32'(1) << w);
    chk("grant_m_rst", m_rst, 1);
    chk("grant_busy", busy, 1);
    chk("m_a", m_a, ea);
    chk("m_b", m_b, eb);
    scramble();
    tick();
    chk("clr_gnt", gnt, 0);
    chk("clr_m_rst", m_rst, 0);
    chk("clr_in_rdy", m_in_rdy, 0);
    scramble();
    tick();
    chk("issue_in_rdy", m_in_rdy, 1);
    cyc = 3;
    while (done === '0 && err === '0 && cyc < TIMEOUT + 8) begin
      scramble();
      tick();
      cyc++;
    end
    ecyc = nv ? 3 + TIMEOUT : 4 + l;
    chk("end_cycle", cyc, ecyc);
    if (nv) begin
      chk("err", err, 32'(1) << w);
      chk("abort_done", done, 0);
      chk("abort_m_rst", m_rst, 1);
      chk("abort_res", res, res_m);
    end else begin
      chk("done", done, 32'(1) << w);
      chk("done_err", err, 0);
      chk("res", res, prod);
      res_m = prod;
    end
    res_seen = res;
    ptr_m    = (w + 1) % NREQ;
    tick();
    chk("back_idle", busy, 0);
    chk("idle_pulses", {gnt, done, err}, 0);
    chk("idle_m_rst", m_rst, 0);
    chk("idle_res", res, res_m);
  endtask

  task automatic reset_mid(input logic [NREQ-1:0] rq, input int n);
    int w;
    lat   = 0;
    never = 1'b1;
    req   = rq;
    w     = pick(rq, ptr_m);
    tick();
    chk("rm_gnt", gnt, 32'(1) << w);
    scramble();
    tick();
    tick();
    repeat (n) tick();
    chk("rm_in_rdy", m_in_rdy, 1);
    #2;
    rst = 1'b0;
    req = '0;
    #1;
    chk("rm_pulses", {gnt, done, err}, 0);
    chk("rm_res", res, 0);
    chk("rm_busy", busy, 0);
    chk("rm_m_rst", m_rst, 1);
    chk("rm_in_rdy_low", m_in_rdy, 0);
    chk("rm_ops", {m_a, m_b}, 0);
    repeat (2) begin
      tick();
      chk("rm_hold_done_err", {done, err}, 0);
    end
    rst   = 1'b1;
    ptr_m = 0;
    res_m = '0;
    tick();
    chk("rm_release_m_rst", m_rst, 0);
    chk("rm_release_busy", busy, 0);
  endtask

  initial begin
    rst       = 1'b0;
    req       = '0;
    a_in      = '0;
    b_in      = '0;
    m_res_rdy = 1'b0;
    m_res     = '0;
    tick();
    tick();
    chk("reset_pulses", {gnt, done, err}, 0);
    chk("reset_res", res, 0);
    chk("reset_busy", busy, 0);
    chk("reset_m_rst", m_rst, 1);
    chk("reset_in_rdy", m_in_rdy, 0);
    chk("reset_ops", {m_a, m_b}, 0);
    rst = 1'b1;
    tick();
    chk("release_m_rst", m_rst, 0);

    a_in = '0;
    b_in = '0;
    a_in[15:0] = 16'h0200;
    b_in[15:0] = 16'h0300;
    run_txn(4'b0001, 4, 1'b0);
    chk("single_res", res_seen, 32'h0006_0000);

    run_txn(4'b0010, 0, 1'b1);
    chk("timeout_res_kept", res_seen, 32'h0006_0000);
    scramble();
    run_txn(4'b1000, 2, 1'b0);

    for (int k = 0; k < 5; k++) begin
      a_in = {16'h0400, 16'h0280, 16'h0180, 16'h0100};
      b_in = {16'h0040, 16'h0200, 16'h0200, 16'h0300};
      run_txn(4'b1111, k, 1'b0);
      chk("rr_order", gnt_seen, 32'(1) << (k % 4));
      if (k == 1) chk("rr_res_1", res_seen, 32'h0003_0000);
    end

    scramble();
    run_txn(4'b0100, 1, 1'b0);
    chk("wrap_gnt2", gnt_seen, 4'b0100);
    scramble();
    run_txn(4'b0011, 1, 1'b0);
    chk("wrap_gnt0", gnt_seen, 4'b0001);
    scramble();
    run_txn(4'b0011, 1, 1'b0);
    chk("wrap_gnt1", gnt_seen, 4'b0010);

    scramble();
    run_txn(4'b0001, TIMEOUT - 1, 1'b0);
    chk("edge_done_wins", res_seen, res_m);

    reset_mid(4'b0010, 5);
    scramble();
    run_txn(4'b0100, 3, 1'b0);
    chk("post_reset_gnt2", gnt_seen, 4'b0100);

    reset_mid(4'b1000, 2);
    scramble();
    run_txn(4'b1111, 0, 1'b0);
    chk("post_reset_ptr0", gnt_seen, 4'b0001);

    for (int t = 0; t < 40; t++) begin
      int  l;
      bit  nv;
      scramble();
      nv = ($urandom_range(0, 9) == 0);
      l  = $urandom_range(0, 8);
      if ($urandom_range(0, 9) == 0) l = TIMEOUT - 1;
      run_txn(req, l, nv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
